simon_seq_engine: RTL

SIMON_SEQ_ENGINE -- requirements
Module: simon_seq_engine

---
 rtl/simon_pkg.sv | 6 +
 rtl/simon_lfsr.sv | 13 +
 rtl/simon_seq_engine.sv | 103 ++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, colour type and LFSR taps for the Simon sequencer
package simon_pkg;
   typedef enum logic [2:0] {IDLE, GROW, SHOW, GAP, INPUT, FAIL, DONE} state_t;
   typedef logic [1:0] color_t;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), zero seed forced to 1
module simon_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);
   import simon_pkg::*;
   // Shift left every cycle, feeding back the parity of the tapped bits
   always_ff @(posedge clk)
      q <= !reset ? (SEED == 8'h00 ? 8'h01 : SEED) : {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/simon_seq_engine.sv
// simon_seq_engine: Simon memory-game sequencer (grow, play back, check echo); SIMON_TIMEOUT_EN adds input inactivity timeout
module simon_seq_engine #(
   parameter int         MAX_LEN       = 32,
   parameter int         PLAY_TICKS    = 4,
   parameter logic [7:0] SEED          = 8'hA5,
   parameter int         TIMEOUT_TICKS = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_valid,
   input  logic [1:0] btn,
   output logic       led_on,
   output logic [1:0] led_color,
   output logic [7:0] level,
   output logic       fail,
   output logic       done
);
   import simon_pkg::*;
   localparam int IW = $clog2(MAX_LEN);
   localparam int TW = $clog2(PLAY_TICKS + 1);
   state_t          state, state_d;
   logic [7:0]      level_d;
   logic [IW-1:0]   idx, idx_d;
   logic [TW-1:0]   tick, tick_d;
   color_t          mem [MAX_LEN];
   logic [7:0]      lfsr_q;
   logic [5:0]      unused_lfsr;
   logic            last, hit, tick_end, timeout;
   simon_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr_q));
   assign unused_lfsr = lfsr_q[7:2];
   assign last        = 8'(idx) == level - 8'd1;
   assign hit         = btn == mem[idx];
   assign tick_end    = tick == TW'(PLAY_TICKS - 1);
   assign led_on      = state == SHOW;
   assign led_color   = led_on ? mem[idx] : 2'b00;
   assign fail        = state == FAIL;
   assign done        = state == DONE;
`ifdef SIMON_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_TICKS + 1);
   logic [CW-1:0] tcnt;
   assign timeout = tcnt == CW'(TIMEOUT_TICKS - 1);
   // Count idle INPUT cycles; any press or leaving INPUT restarts the count
   always_ff @(posedge clk)
      tcnt <= (!reset || state != INPUT || btn_valid) ? '0 : tcnt + 1'b1;
`else
   localparam int unused_timeout = TIMEOUT_TICKS;
   assign timeout = 1'b0;
`endif
   // Next-state and datapath updates for the game flow
   always_comb begin
      state_d = state;
      level_d = level;
      idx_d   = idx;
      tick_d  = tick;
      case (state)
         IDLE, FAIL, DONE: if (start) begin
            state_d = GROW;
            level_d = 8'd0;
         end
         GROW: begin
            state_d = SHOW;
            level_d = level + 8'd1;
            idx_d   = '0;
            tick_d  = '0;
         end
         SHOW: begin
            tick_d  = tick_end ? '0 : tick + 1'b1;
            state_d = tick_end ? GAP : SHOW;
         end
         GAP: begin
            tick_d = tick_end ? '0 : tick + 1'b1;
            if (tick_end) begin
               state_d = last ? INPUT : SHOW;
               idx_d   = last ? '0 : idx + 1'b1;
            end
         end
         INPUT: if (btn_valid && !hit) state_d = FAIL;
            else if (btn_valid) begin
               idx_d = last ? '0 : idx + 1'b1;
               if (last) state_d = level < 8'(MAX_LEN) ? GROW : DONE;
            end
            else if (timeout) state_d = FAIL;
         default: state_d = IDLE;
      endcase
   end
   // State and index registers with synchronous active-low reset
   always_ff @(posedge clk)
      if (!reset) begin
         state <= IDLE;
         level <= 8'd0;
         idx   <= '0;
         tick  <= '0;
      end else begin
         state <= state_d;
         level <= level_d;
         idx   <= idx_d;
         tick  <= tick_d;
      end
   // Append the new random colour while growing; contents survive reset
   always_ff @(posedge clk)
      if (reset && state == GROW) mem[level[IW-1:0]] <= lfsr_q[1:0];
endmodule
